// File: rtl/mnacidpro_valve_sequencer.sv
// rtl/mnacidpro_valve_sequencer.sv - pneumatic valve/pump sequencer for the mnacidpro_pads purification protocol
// Optional abort/purge path enabled by defining MNACIDPRO_ABORT_EN.
module mnacidpro_valve_sequencer #(
  parameter int SIZE            = 2,
  parameter int PHASE_CYCLES    = 4,
  parameter int SETTLE_CYCLES   = 8,
  parameter int BEAD_STROKES    = 4,
  parameter int LYSIS_STROKES   = 8,
  parameter int WASH_STROKES    = 6,
  parameter int ELUTE_STROKES   = 4,
  parameter int COLLECT_STROKES = 2,
  parameter int CW              = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] chan,
`ifdef MNACIDPRO_ABORT_EN
  input  logic          abort,
  output logic          aborted,
`endif
  output logic          busy,
  output logic          done,
  output logic          lysis_ctrl,
  output logic          wash_ctrl,
  output logic          elute_ctrl,
  output logic          dead_end_ctrl,
  output logic          vertical_ctrl,
  output logic          horiz_ctrl,
  output logic          waste_ctrl,
  output logic          bead_ctrl,
  output logic          loop_exit_ctrl,
  output logic          bead_trap_ctrl,
  output logic          collect_ctrl,
  output logic [2:0]    pump,
  output logic [CW-1:0] collect_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAD,
    S_LYSIS,
    S_WASH,
    S_ELUTE,
    S_COLLECT,
`ifdef MNACIDPRO_ABORT_EN
    S_PURGE,
`endif
    S_DONE
  } state_t;

  localparam int I_LYSIS = 10, I_WASH = 9, I_ELUTE = 8, I_DEAD_END = 7, I_VERTICAL = 6;
  localparam int I_HORIZ = 5, I_WASTE = 4, I_BEAD = 3, I_LOOP_EXIT = 2, I_BEAD_TRAP = 1;
  localparam int I_COLLECT = 0;

  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0]   PHASE_LAST  = 16'(PHASE_CYCLES - 1);
  localparam logic [CW:0]   SIZE_W      = (CW+1)'(SIZE);
  localparam logic [CW-1:0] CHAN_MAX    = CW'(SIZE - 1);

  state_t        st, st_n;
  logic          pumping, pumping_n;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    phase, phase_n;
  logic [15:0]   strokes, strokes_n;
  logic [CW-1:0] chan_q, chan_n;
  logic [10:0]   valves;

  // Bits set in the mask are the valves vented (opened) in that state.
  function automatic logic [10:0] open_mask(input state_t s);
    logic [10:0] m;
    m = '0;
    case (s)
      S_BEAD:    begin m[I_BEAD] = 1'b1; m[I_HORIZ] = 1'b1; m[I_WASTE] = 1'b1; end
      S_LYSIS:   begin m[I_LYSIS] = 1'b1; m[I_VERTICAL] = 1'b1; m[I_LOOP_EXIT] = 1'b1; m[I_WASTE] = 1'b1; end
      S_WASH:    begin m[I_WASH] = 1'b1; m[I_HORIZ] = 1'b1; m[I_WASTE] = 1'b1; end
      S_ELUTE:   begin m[I_ELUTE] = 1'b1; m[I_DEAD_END] = 1'b1; m[I_LOOP_EXIT] = 1'b1; end
      S_COLLECT: begin m[I_COLLECT] = 1'b1; m[I_LOOP_EXIT] = 1'b1; end
`ifdef MNACIDPRO_ABORT_EN
      S_PURGE:   begin m[I_WASTE] = 1'b1; m[I_HORIZ] = 1'b1; end
`endif
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] stroke_last(input state_t s);
    case (s)
      S_BEAD:  return 16'(BEAD_STROKES - 1);
      S_LYSIS: return 16'(LYSIS_STROKES - 1);
      S_WASH:  return 16'(WASH_STROKES - 1);
      S_ELUTE: return 16'(ELUTE_STROKES - 1);
`ifdef MNACIDPRO_ABORT_EN
      S_PURGE: return 16'd1;
`endif
      default: return 16'(COLLECT_STROKES - 1);
    endcase
  endfunction

  function automatic state_t next_step(input state_t s);
    case (s)
      S_BEAD:  return S_LYSIS;
      S_LYSIS: return S_WASH;
      S_WASH:  return S_ELUTE;
      S_ELUTE: return S_COLLECT;
      default: return S_DONE;
    endcase
  endfunction

  // Never returns 000: every phase keeps at least one pump valve sealed.
  function automatic logic [2:0] pump_pattern(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b101;
      3'd1:    return 3'b100;
      3'd2:    return 3'b110;
      3'd3:    return 3'b010;
      3'd4:    return 3'b011;
      3'd5:    return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic is_active(input state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

  always_comb begin
    st_n      = st;
    pumping_n = pumping;
    cnt_n     = cnt;
    phase_n   = phase;
    strokes_n = strokes;
    chan_n    = chan_q;
    case (st)
      S_IDLE: begin
        if (start) begin
          st_n      = S_BEAD;
          pumping_n = 1'b0;
          cnt_n     = '0;
          phase_n   = '0;
          strokes_n = '0;
          chan_n    = ({1'b0, chan} >= SIZE_W) ? CHAN_MAX : chan;
        end
      end
      S_DONE: st_n = S_IDLE;
      default: begin
        if (!pumping) begin
          if (cnt == SETTLE_LAST) begin
            pumping_n = 1'b1;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end else if (cnt != PHASE_LAST) begin
          cnt_n = cnt + 16'd1;
        end else begin
          cnt_n = '0;
          if (phase != 3'd5) begin
            phase_n = phase + 3'd1;
          end else begin
            phase_n = '0;
            if (strokes != stroke_last(st)) begin
              strokes_n = strokes + 16'd1;
            end else begin
              strokes_n = '0;
              pumping_n = 1'b0;
              st_n      = next_step(st);
            end
          end
        end
`ifdef MNACIDPRO_ABORT_EN
        // Purge pumps straight away; the valve map change is to a drain path.
        if (abort && st != S_PURGE) begin
          st_n      = S_PURGE;
          pumping_n = 1'b1;
          cnt_n     = '0;
          phase_n   = '0;
          strokes_n = '0;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      pumping     <= 1'b0;
      cnt         <= '0;
      phase       <= '0;
      strokes     <= '0;
      chan_q      <= '0;
      valves      <= '1;
      pump        <= 3'b111;
      busy        <= 1'b0;
      done        <= 1'b0;
      collect_sel <= '0;
`ifdef MNACIDPRO_ABORT_EN
      aborted     <= 1'b0;
`endif
    end else begin
      st          <= st_n;
      pumping     <= pumping_n;
      cnt         <= cnt_n;
      phase       <= phase_n;
      strokes     <= strokes_n;
      chan_q      <= chan_n;
      valves      <= ~open_mask(st_n);
      pump        <= (pumping_n && is_active(st_n)) ? pump_pattern(phase_n) : 3'b111;
      busy        <= is_active(st_n);
      done        <= (st_n == S_DONE);
      collect_sel <= (st_n == S_COLLECT) ? chan_n : '0;
`ifdef MNACIDPRO_ABORT_EN
      aborted     <= (st == S_PURGE) && (st_n == S_DONE);
`endif
    end
  end

  assign lysis_ctrl     = valves[I_LYSIS];
  assign wash_ctrl      = valves[I_WASH];
  assign elute_ctrl     = valves[I_ELUTE];
  assign dead_end_ctrl  = valves[I_DEAD_END];
  assign vertical_ctrl  = valves[I_VERTICAL];
  assign horiz_ctrl     = valves[I_HORIZ];
  assign waste_ctrl     = valves[I_WASTE];
  assign bead_ctrl      = valves[I_BEAD];
  assign loop_exit_ctrl = valves[I_LOOP_EXIT];
  assign bead_trap_ctrl = valves[I_BEAD_TRAP];
  assign collect_ctrl   = valves[I_COLLECT];

endmodule

// File: tb/tb_mnacidpro_valve_sequencer.sv
// tb/tb_mnacidpro_valve_sequencer.sv - self-checking bench for mnacidpro_valve_sequencer
module tb_mnacidpro_valve_sequencer;
  localparam int CW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_f = 1'b0;
  logic [CW-1:0] chan = '0;
  logic busy, done, lysis_c, wash_c, elute_c, dead_c, vert_c, horiz_c, waste_c, bead_c, loop_c, trap_c, coll_c;
  logic [2:0] pump;
  logic [CW-1:0] sel;
  logic f_busy, f_done, f_ly, f_wa, f_el, f_de, f_ve, f_ho, f_ws, f_be, f_lo, f_tr, f_co;
  logic [2:0] f_pump;
  logic [CW-1:0] f_sel;
`ifdef MNACIDPRO_ABORT_EN
  logic abort = 1'b0;
  logic abort_f = 1'b0;
  logic aborted, f_aborted;
`endif

  mnacidpro_valve_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan(chan),
`ifdef MNACIDPRO_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done), .lysis_ctrl(lysis_c), .wash_ctrl(wash_c), .elute_ctrl(elute_c),
    .dead_end_ctrl(dead_c), .vertical_ctrl(vert_c), .horiz_ctrl(horiz_c), .waste_ctrl(waste_c),
    .bead_ctrl(bead_c), .loop_exit_ctrl(loop_c), .bead_trap_ctrl(trap_c), .collect_ctrl(coll_c),
    .pump(pump), .collect_sel(sel)
  );

  mnacidpro_valve_sequencer #(.PHASE_CYCLES(1), .BEAD_STROKES(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start_f), .chan(chan),
`ifdef MNACIDPRO_ABORT_EN
    .abort(abort_f), .aborted(f_aborted),
`endif
    .busy(f_busy), .done(f_done), .lysis_ctrl(f_ly), .wash_ctrl(f_wa), .elute_ctrl(f_el),
    .dead_end_ctrl(f_de), .vertical_ctrl(f_ve), .horiz_ctrl(f_ho), .waste_ctrl(f_ws),
    .bead_ctrl(f_be), .loop_exit_ctrl(f_lo), .bead_trap_ctrl(f_tr), .collect_ctrl(f_co),
    .pump(f_pump), .collect_sel(f_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic           busy;
    logic           done;
    logic           lysis;
    logic           waste;
    logic           collect;
    logic [2:0]     pump;
    logic [CW-1:0]  sel;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t mk(input int c, input logic b, input logic d, input logic ly,
                              input logic wa, input logic co, input logic [2:0] p, input logic [CW-1:0] s);
    exp_t e;
    e.cyc = c; e.busy = b; e.done = d; e.lysis = ly; e.waste = wa; e.collect = co; e.pump = p; e.sel = s;
    return e;
  endfunction

  // Scoreboard: compare the head of the queue when its cycle comes up.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_m = q.pop_front();
      if (e_m.cyc != cyc) chk("sched", cyc, e_m.cyc);
      else begin
        chk("busy", busy, e_m.busy);
        chk("done", done, e_m.done);
        chk("lysis_ctrl", lysis_c, e_m.lysis);
        chk("waste_ctrl", waste_c, e_m.waste);
        chk("collect_ctrl", coll_c, e_m.collect);
        chk("pump", pump, e_m.pump);
        chk("collect_sel", sel, e_m.sel);
        chk("bead_trap_ctrl", trap_c, 1'b1);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (q.size() > 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  exp_t nom[13];
  exp_t b2b[5];
  logic [2:0] pat[7];
  int t, viol;

  initial begin
    #(300000 * 10);
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    nom[0]  = mk(0,   0, 0, 1, 1, 1, 3'b111, 0);
    nom[1]  = mk(1,   1, 0, 1, 0, 1, 3'b111, 0);
    nom[2]  = mk(9,   1, 0, 1, 0, 1, 3'b101, 0);
    nom[3]  = mk(104, 1, 0, 1, 0, 1, 3'b001, 0);
    nom[4]  = mk(105, 1, 0, 0, 0, 1, 3'b111, 0);
    nom[5]  = mk(113, 1, 0, 0, 0, 1, 3'b101, 0);
    nom[6]  = mk(304, 1, 0, 0, 0, 1, 3'b001, 0);
    nom[7]  = mk(305, 1, 0, 1, 0, 1, 3'b111, 0);
    nom[8]  = mk(560, 1, 0, 1, 1, 1, 3'b001, 0);
    nom[9]  = mk(561, 1, 0, 1, 1, 0, 3'b111, 1);
    nom[10] = mk(616, 1, 0, 1, 1, 0, 3'b001, 1);
    nom[11] = mk(617, 0, 1, 1, 1, 1, 3'b111, 0);
    nom[12] = mk(618, 0, 0, 1, 1, 1, 3'b111, 0);
    b2b[0]  = mk(617,  0, 1, 1, 1, 1, 3'b111, 0);
    b2b[1]  = mk(618,  0, 0, 1, 1, 1, 3'b111, 0);
    b2b[2]  = mk(619,  1, 0, 1, 0, 1, 3'b111, 0);
    b2b[3]  = mk(1235, 0, 1, 1, 1, 1, 3'b111, 0);
    b2b[4]  = mk(1236, 0, 0, 1, 1, 1, 3'b111, 0);
    pat[0] = 3'b101; pat[1] = 3'b100; pat[2] = 3'b110; pat[3] = 3'b010;
    pat[4] = 3'b011; pat[5] = 3'b001; pat[6] = 3'b111;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pump", pump, 3'b111);
    chk("reset_valves", {lysis_c, wash_c, elute_c, dead_c, vert_c, horiz_c, waste_c, bead_c, loop_c, trap_c, coll_c}, 11'h7ff);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Nominal run with chan=1; a start pulse mid-run with chan=0 must be ignored.
    t = cyc; chan = 1'b1; start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      e_m = nom[i];
      e_m.cyc = t + nom[i].cyc;
      q.push_back(e_m);
    end
    @(posedge clk); #1; start = 1'b0;
    wait_cyc(t + 50); chan = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_drain(1000);

    // Asynchronous reset in the middle of LYSIS pumping.
    wait_cyc(cyc + 3);
    t = cyc; chan = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_cyc(t + 200);
    chk("pre_reset_lysis", lysis_c, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valves", {lysis_c, wash_c, elute_c, dead_c, vert_c, horiz_c, waste_c, bead_c, loop_c, trap_c, coll_c}, 11'h7ff);
    chk("async_reset_pump", pump, 3'b111);
    chk("async_reset_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || pump !== 3'b111 || lysis_c !== 1'b1) viol++;
    end
    chk("post_reset_idle", viol, 0);

    // Pump phase order on the fast instance.
    @(posedge clk); #1;
    t = cyc; start_f = 1'b1;
    @(posedge clk); #1; start_f = 1'b0;
    for (int k = 9; k <= 15; k++) begin
      wait_cyc(t + k);
      chk($sformatf("fast_pump_T+%0d", k), f_pump, pat[k-9]);
    end

    // Back-to-back runs with start held high.
    wait_cyc(t + 400);
    t = cyc; chan = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e_m = b2b[i];
      e_m.cyc = t + b2b[i].cyc;
      q.push_back(e_m);
    end
    wait_cyc(t + 700); start = 1'b0;
    wait_drain(1000);

`ifdef MNACIDPRO_ABORT_EN
    wait_cyc(cyc + 3);
    t = cyc; chan = 1'b0; start = 1'b1;
    q.push_back(mk(t + 120, 1, 0, 0, 0, 1, 3'b100, 0));
    q.push_back(mk(t + 121, 1, 0, 1, 0, 1, 3'b101, 0));
    q.push_back(mk(t + 168, 1, 0, 1, 0, 1, 3'b001, 0));
    q.push_back(mk(t + 169, 0, 1, 1, 1, 1, 3'b111, 0));
    q.push_back(mk(t + 170, 0, 0, 1, 1, 1, 3'b111, 0));
    @(posedge clk); #1; start = 1'b0;
    wait_cyc(t + 120); abort = 1'b1;
    wait_cyc(t + 121); abort = 1'b0;
    chk("purge_horiz", horiz_c, 1'b0);
    chk("purge_aborted_low", aborted, 1'b0);
    wait_cyc(t + 169);
    chk("aborted_pulse", aborted, 1'b1);
    wait_cyc(t + 170);
    chk("aborted_clear", aborted, 1'b0);
    wait_drain(500);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
